// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states,
// wait-latency limits and the alignment / byte-enable helpers.
package mem_responder_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 7;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Size code 11 behaves as a word access everywhere.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << a;
      SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word RAM with per-byte write enables: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: level-held read/write requests from the control unit,
// byte/half/word accesses with a fixed read wait, answered by a one-cycle ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("mem_responder: READ_LAT out of range");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [1:0]         size_q;
  logic               sx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               ready_q;
  logic               busy_q;
  logic               misalign_q;

  logic [31:0]        ram_word;
  logic [31:0]        ram_wdata;
  logic [3:0]         ram_be;
  logic               ram_we;
  logic [31:0]        rdata_d;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;

  // Upper address bits alias onto the RAM.
  logic               unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  // A reset coinciding with the commit edge must suppress the store.
  assign ram_we = (state_q == ST_WRITE) && !reset;
  assign ram_be = byte_en(size_q, addr_q[1:0]);

  always_comb begin
    ram_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_word)
  );

  // Little-endian lane select, shifted to the LSBs, then extended.
  always_comb begin
    byte_v  = ram_word[7:0];
    case (addr_q[1:0])
      2'd0:    byte_v = ram_word[7:0];
      2'd1:    byte_v = ram_word[15:8];
      2'd2:    byte_v = ram_word[23:16];
      default: byte_v = ram_word[31:24];
    endcase
    half_v  = addr_q[1] ? ram_word[31:16] : ram_word[15:0];
    rdata_d = ram_word;
    case (size_q)
      SZ_BYTE: rdata_d = {{24{sx_q & byte_v[7]}}, byte_v};
      SZ_HALF: rdata_d = {{16{sx_q & half_v[15]}}, half_v};
      default: rdata_d = ram_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= SZ_WORD;
      sx_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_write || mem_read) begin
            addr_q <= addr[ADDR_W+1:0];
            size_q <= size;
            busy_q <= 1'b1;
            if (misaligned(size, addr[1:0])) begin
              state_q    <= ST_DONE;
              ready_q    <= 1'b1;
              misalign_q <= 1'b1;
            end else if (mem_write) begin
              wdata_q <= wdata;
              state_q <= ST_WRITE;
            end else begin
              sx_q    <= sign_ext;
              cnt_q   <= CNT_W'(READ_LAT - 1);
              state_q <= ST_READ_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= rdata_d;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WRITE: begin
          ready_q <= 1'b1;
          state_q <= ST_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign misalign = misalign_q;

endmodule
